// File: rtl/neg_issue_ctrl.sv
// Issue controller for the negation unit: buffers decoder commands, blocks on
// RAW/WAW hazards through a per-register scoreboard, issues and writes back.
module neg_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int NREGS      = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_src,
  input  logic [3:0]  cmd_dest,
  output logic [3:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        neg_en,
  output logic [31:0] neg_value,
  output logic [3:0]  neg_dest_addr,
  input  logic        neg_done,
  input  logic [31:0] neg_out_value,
  input  logic [3:0]  neg_out_dest,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        idle,
  output logic [7:0]  stall_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dest;
  } cmd_t;

  cmd_t [FIFO_DEPTH-1:0] fifo_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [NREGS-1:0]      sb_q, sb_d;
  logic [7:0]            stall_q, stall_d;
  logic                  neg_en_q, wb_en_q;
  logic [31:0]           neg_value_q, wb_data_q;
  logic [3:0]            neg_dest_q, wb_addr_q;

  cmd_t head;
  logic nonempty, push, issue;

  assign cmd_ready = (count_q != CW'(FIFO_DEPTH));

  always_comb begin
    head     = fifo_q[rd_ptr_q];
    nonempty = (count_q != '0);
    push     = cmd_valid && cmd_ready;
    // Hazard check sees only the registered scoreboard; a clear this cycle
    // lets the waiting command go on the following edge.
    issue    = nonempty && !sb_q[head.src] && !sb_q[head.dest];

    count_d = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear is applied after set so an illegal same-cycle collision clears.
    sb_d = sb_q;
    if (issue)    sb_d[head.dest]    = 1'b1;
    if (neg_done) sb_d[neg_out_dest] = 1'b0;

    stall_d = stall_q;
    if (nonempty && !issue && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sb_q        <= '0;
      stall_q     <= '0;
      neg_en_q    <= 1'b0;
      neg_value_q <= '0;
      neg_dest_q  <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{src: cmd_src, dest: cmd_dest};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (issue) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        neg_value_q <= rf_rd_data;
        neg_dest_q  <= head.dest;
      end
      neg_en_q <= issue;
      count_q  <= count_d;
      sb_q     <= sb_d;
      stall_q  <= stall_d;
      wb_en_q  <= neg_done;
      if (neg_done) begin
        wb_addr_q <= neg_out_dest;
        wb_data_q <= neg_out_value;
      end
    end
  end

  assign rf_rd_addr    = nonempty ? head.src : 4'd0;
  assign neg_en        = neg_en_q;
  assign neg_value     = neg_value_q;
  assign neg_dest_addr = neg_dest_q;
  assign wb_en         = wb_en_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign stall_cnt     = stall_q;
  assign idle          = (count_q == '0) && (sb_q == '0) && !wb_en_q;

endmodule

// File: tb/tb_neg_issue_ctrl.sv
// Bench for neg_issue_ctrl: write-through register file, 2-stage negation
// unit and a program-order reference model that predicts every writeback.
module tb_neg_issue_ctrl;
  localparam logic [31:0] SGN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_src = '0, cmd_dest = '0;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        neg_en;
  logic [31:0] neg_value;
  logic [3:0]  neg_dest_addr;
  logic        neg_done;
  logic [31:0] neg_out_value;
  logic [3:0]  neg_out_dest;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        idle;
  logic [7:0]  stall_cnt;

  always #5 clk = ~clk;

  neg_issue_ctrl #(.FIFO_DEPTH(4), .NREGS(16)) dut (
    .clk(clk), .nRst(nRst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dest(cmd_dest), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .neg_en(neg_en), .neg_value(neg_value),
    .neg_dest_addr(neg_dest_addr), .neg_done(neg_done),
    .neg_out_value(neg_out_value), .neg_out_dest(neg_out_dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .idle(idle),
    .stall_cnt(stall_cnt)
  );

  // Environment: register file, negation unit and reference model
  logic [31:0] rf [16];
  logic [31:0] m_rf [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        hold = 1'b0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_d, s2_d;
  logic [3:0]  s1_t, s2_t;
  logic [31:0] r;
  int          cyc = 0;

  typedef struct { logic [3:0] a; logic [31:0] d; } wb_t;
  wb_t exp_q[$];

  int total = 0;
  int bad   = 0;

  assign rf_rd_data    = (wb_en && wb_addr == rf_rd_addr) ? wb_data : rf[rf_rd_addr];
  assign neg_done      = s2_v && !hold;
  assign neg_out_value = s2_d;
  assign neg_out_dest  = s2_t;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!nRst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      m_rf = rf;
      exp_q.delete();
    end else begin
      if (!hold) begin
        s1_v <= neg_en; s1_d <= neg_value ^ SGN; s1_t <= neg_dest_addr;
        s2_v <= s1_v;   s2_d <= s1_d;            s2_t <= s1_t;
      end
      if (cmd_valid && cmd_ready) begin
        r = m_rf[cmd_src] ^ SGN;
        m_rf[cmd_dest] = r;
        exp_q.push_back('{cmd_dest, r});
      end
    end
    if (wb_en) rf[wb_addr] <= wb_data;
    else if (ld_en) begin
      rf[ld_addr] <= ld_data;
      m_rf[ld_addr] = ld_data;
    end
  end

  // Every writeback must match the next predicted result in program order
  always @(negedge clk) begin
    wb_t e;
    if (nRst && wb_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got addr=%0h data=%0h required none", wb_addr, wb_data);
      end else begin
        e = exp_q.pop_front();
        if (wb_addr !== e.a || wb_data !== e.d) begin
          bad++;
          $display("FAIL wb_order got addr=%0h data=%0h required addr=%0h data=%0h",
                   wb_addr, wb_data, e.a, e.d);
        end
      end
    end
  end

  int ne_q[$];
  int wbc_q[$];
  logic [3:0]  wba_q[$];
  logic [31:0] wbd_q[$];
  int last_acc;

  task automatic clr();
    ne_q.delete(); wbc_q.delete(); wba_q.delete(); wbd_q.delete();
  endtask

  task automatic step();
    @(negedge clk);
    if (neg_en) ne_q.push_back(cyc);
    if (wb_en) begin
      wbc_q.push_back(cyc); wba_q.push_back(wb_addr); wbd_q.push_back(wb_data);
    end
  endtask

  task automatic push_cmd(input logic [3:0] s, input logic [3:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_src = s; cmd_dest = d;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL push_timeout got ready=0 required ready=1");
    end
    last_acc = cyc + 1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!idle && n < 400) begin step(); n++; end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL drain_timeout got idle=0 required idle=1");
    end
    step();
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [31:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    step();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (2) step();
    total++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
      bad++; $display("FAIL reset_ready_idle got %b%b required 11", cmd_ready, idle);
    end
    total++;
    if (neg_en !== 1'b0 || wb_en !== 1'b0 || stall_cnt !== 8'd0 || rf_rd_addr !== 4'd0) begin
      bad++; $display("FAIL reset_outs got neg_en=%b wb_en=%b stall=%0d rd=%0h required 0",
                      neg_en, wb_en, stall_cnt, rf_rd_addr);
    end
    total++;
    if (neg_value !== 32'd0 || neg_dest_addr !== 4'd0 || wb_addr !== 4'd0 || wb_data !== 32'd0) begin
      bad++; $display("FAIL reset_data got nv=%0h nd=%0h wa=%0h wd=%0h required 0",
                      neg_value, neg_dest_addr, wb_addr, wb_data);
    end
    nRst = 1'b1;
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
  endtask

  task automatic test_single();
    clr();
    set_reg(4'd3, 32'h3F80_0000);
    push_cmd(4'd3, 4'd5);
    repeat (8) step();
    total++;
    if (ne_q.size() != 1 || ne_q[0] != last_acc + 1) begin
      bad++; $display("FAIL single_issue got n=%0d required one at edge %0d", ne_q.size(), last_acc + 1);
    end
    total++;
    if (neg_value !== 32'h3F80_0000 || neg_dest_addr !== 4'd5) begin
      bad++; $display("FAIL single_operand got %0h/%0h required 3f800000/5", neg_value, neg_dest_addr);
    end
    total++;
    if (wbc_q.size() != 1 || wbc_q[0] != last_acc + 4 || wba_q[0] !== 4'd5 || wbd_q[0] !== 32'hBF80_0000) begin
      bad++; $display("FAIL single_wb got n=%0d required one wb at edge %0d to 5 = bf800000",
                      wbc_q.size(), last_acc + 4);
    end
    total++;
    if (rf[5] !== 32'hBF80_0000 || idle !== 1'b1) begin
      bad++; $display("FAIL single_rf got R5=%0h idle=%b required bf800000 1", rf[5], idle);
    end
  endtask

  task automatic test_raw();
    logic [31:0] v = $urandom;
    int s0, a1;
    set_reg(4'd1, v);
    clr();
    s0 = int'(stall_cnt);
    push_cmd(4'd1, 4'd2); a1 = last_acc;
    push_cmd(4'd2, 4'd4);
    drain();
    total++;
    if (ne_q.size() != 2 || wbc_q.size() != 2 || ne_q[1] != wbc_q[0] + 1 || ne_q[1] != a1 + 5) begin
      bad++; $display("FAIL raw_issue got n=%0d second=%0d required second at edge %0d",
                      ne_q.size(), (ne_q.size() > 1) ? ne_q[1] : -1, a1 + 5);
    end
    total++;
    if (int'(stall_cnt) - s0 != 3) begin
      bad++; $display("FAIL raw_stall got %0d required 3", int'(stall_cnt) - s0);
    end
    total++;
    if (rf[4] !== v) begin
      bad++; $display("FAIL raw_result got %0h required %0h", rf[4], v);
    end
  endtask

  task automatic test_back_to_back();
    int s0, a0;
    clr();
    s0 = int'(stall_cnt);
    push_cmd(4'd0, 4'd8); a0 = last_acc;
    push_cmd(4'd1, 4'd9);
    push_cmd(4'd2, 4'd10);
    push_cmd(4'd3, 4'd11);
    drain();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ne_q.size() != 4 || wbc_q.size() != 4 || ne_q[i] != a0 + 1 + i ||
          wbc_q[i] != a0 + 4 + i || wba_q[i] !== 4'(8 + i)) begin
        bad++; $display("FAIL b2b_slot%0d got issue/wb count %0d/%0d required consecutive to %0d",
                        i, ne_q.size(), wbc_q.size(), 8 + i);
      end
    end
    total++;
    if (int'(stall_cnt) != s0) begin
      bad++; $display("FAIL b2b_stall got %0d required %0d", stall_cnt, s0);
    end
  endtask

  task automatic test_full();
    int ss[6] = '{0, 7, 1, 2, 3, 4};
    int dd[6] = '{7, 12, 13, 14, 15, 8};
    logic rdy[$];
    int i = 0, n = 0;
    logic early;
    clr();
    while (i < 6 && n < 40) begin
      cmd_valid = 1'b1; cmd_src = 4'(ss[i]); cmd_dest = 4'(dd[i]);
      rdy.push_back(cmd_ready);
      if (cmd_ready) i++;
      step(); n++;
    end
    cmd_valid = 1'b0;
    drain();
    early = 1'b1;
    for (int k = 0; k < 5 && k < rdy.size(); k++) early &= rdy[k];
    total++;
    if (rdy.size() < 7 || !early || rdy[5] !== 1'b0 || rdy[6] !== 1'b1) begin
      bad++; $display("FAIL full_ready got n=%0d required ready 1,1,1,1,1,0,1", rdy.size());
    end
    total++;
    if (wbc_q.size() != 6) begin
      bad++; $display("FAIL full_count got %0d required 6", wbc_q.size());
    end
  endtask

  task automatic test_waw();
    clr();
    push_cmd(4'd0, 4'd6);
    push_cmd(4'd1, 4'd6);
    drain();
    total++;
    if (ne_q.size() != 2 || wbc_q.size() != 2 || ne_q[1] != wbc_q[0] + 1) begin
      bad++; $display("FAIL waw_wait got n=%0d required second issue after first wb", ne_q.size());
    end
    total++;
    if (rf[6] !== (m_rf[1] ^ SGN)) begin
      bad++; $display("FAIL waw_final got %0h required %0h", rf[6], m_rf[1] ^ SGN);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    push_cmd(4'd0, 4'd7);
    push_cmd(4'd7, 4'd1);
    push_cmd(4'd7, 4'd2);
    push_cmd(4'd7, 4'd3);
    nRst = 1'b0;
    #1;
    total++;
    if (neg_en !== 1'b0 || neg_value !== 32'd0 || neg_dest_addr !== 4'd0 ||
        wb_en !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 32'd0) begin
      bad++; $display("FAIL midreset_outs got ne=%b nv=%0h wb=%b wd=%0h required 0",
                      neg_en, neg_value, wb_en, wb_data);
    end
    total++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1 || stall_cnt !== 8'd0 || rf_rd_addr !== 4'd0) begin
      bad++; $display("FAIL midreset_state got ready=%b idle=%b stall=%0d required 1 1 0",
                      cmd_ready, idle, stall_cnt);
    end
    repeat (2) step();
    nRst = 1'b1;
    clr();
    push_cmd(4'd5, 4'd9);
    drain();
    total++;
    if (wbc_q.size() != 1 || wba_q[0] !== 4'd9) begin
      bad++; $display("FAIL midreset_after got %0d wbs required 1 to R9", wbc_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_src   = 4'($urandom_range(0, 15));
      cmd_dest  = 4'($urandom_range(0, 15));
      step();
    end
    cmd_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rf[i] !== m_rf[i]) begin
        bad++; $display("FAIL rand_R%0d got %0h required %0h", i, rf[i], m_rf[i]);
      end
    end
  endtask

  task automatic test_stall_sat();
    clr();
    push_cmd(4'd0, 4'd7);
    push_cmd(4'd7, 4'd8);
    repeat (2) step();
    hold = 1'b1;
    repeat (300) step();
    total++;
    if (stall_cnt !== 8'hFF) begin
      bad++; $display("FAIL stall_sat got %0d required 255", stall_cnt);
    end
    hold = 1'b0;
    drain();
    total++;
    if (stall_cnt !== 8'hFF || wbc_q.size() != 2) begin
      bad++; $display("FAIL stall_hold got %0d wbs=%0d required 255 2", stall_cnt, wbc_q.size());
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_raw();
    test_back_to_back();
    test_full();
    test_waw();
    test_reset_mid();
    test_random();
    test_stall_sat();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
